sca_frame_sender: RTL and testbench

Upstream driver for the SAKURA-G SCA unlock target. It accepts one parallel frame per handshake: flip-bit index in the upper 16 bits, DUT input pattern in the lower bits. It serialises the frame MSB-first onto the header pins (`sda`, `sclk`) so the target's negedge-sampling serial receiver captures it in order. It then issues one `flip_clk` pulse, which makes the target's DUT controller load the frame and toggle the indexed input. It also generates the target's active-low header reset on request.

---
 rtl/sca_frame_sender_if.sv | 14 +
 rtl/sca_frame_sender.sv | 109 ++++++++++
 tb/tb_sca_frame_sender.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sca_frame_sender_if.sv
// sca_frame_sender_if: frame handshake plus target header pins of the SCA frame sender.
interface sca_frame_sender_if #(parameter int DATA_LEN = 24);
   logic [DATA_LEN-1:0] frame_data;
   logic frame_valid, frame_ready, tgt_rst_req;
   logic sda, sclk, flip_clk, tgt_reset_n, busy, done;
   modport master (
      output frame_data, frame_valid, tgt_rst_req,
      input  frame_ready, sda, sclk, flip_clk, tgt_reset_n, busy, done
   );
   modport slave (
      input  frame_data, frame_valid, tgt_rst_req,
      output frame_ready, sda, sclk, flip_clk, tgt_reset_n, busy, done
   );
endinterface

// File: rtl/sca_frame_sender.sv
// sca_frame_sender: shifts a frame MSB-first onto sda/sclk, then strobes flip_clk; also pulses the target reset.
module sca_frame_sender #(
   parameter int DATA_LEN = 24,
   parameter int CLK_DIV  = 2,
   parameter int FLIP_GAP = 3,
   parameter int RST_LEN  = 8
) (
   input logic clk,
   input logic reset,
   sca_frame_sender_if.slave f
);
   localparam int TMAX = CLK_DIV > FLIP_GAP ? (CLK_DIV > RST_LEN ? CLK_DIV : RST_LEN)
                                            : (FLIP_GAP > RST_LEN ? FLIP_GAP : RST_LEN);
   localparam int TW = $clog2(TMAX + 1);
   localparam int BW = $clog2(DATA_LEN + 1);
   localparam logic [TW-1:0] DIV_L = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] GAP_L = TW'(FLIP_GAP - 1);
   localparam logic [TW-1:0] RST_L = TW'(RST_LEN - 1);
   typedef enum logic [2:0] {IDLE, TRST, SETUP, HIGH, HOLD, GAP, FLIP} state_t;
   state_t state_q, state_d;
   logic [DATA_LEN-1:0] sh_q, sh_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic sda_q, sda_d, sclk_q, sclk_d, flip_q, flip_d;
   logic rstn_q, rstn_d, done_q, done_d, busy_q, busy_d;
   logic last;
   // tmr counts down the remaining cycles of the current timed state
   always_comb begin
      last = tmr_q == '0;
      state_d = state_q;
      sh_d = sh_q;
      bit_d = bit_q;
      tmr_d = last ? tmr_q : tmr_q - TW'(1);
      case (state_q)
         IDLE: begin
            if (f.tgt_rst_req) begin
               state_d = TRST;
               tmr_d = RST_L;
            end else if (f.frame_valid) begin
               state_d = SETUP;
               sh_d = f.frame_data;
               bit_d = BW'(DATA_LEN);
               tmr_d = DIV_L;
            end
         end
         TRST: state_d = last ? IDLE : TRST;
         SETUP: begin
            if (last) begin
               state_d = HIGH;
               tmr_d = DIV_L;
            end
         end
         HIGH: state_d = last ? HOLD : HIGH;
         HOLD: begin
            sh_d = sh_q << 1;
            bit_d = bit_q - BW'(1);
            state_d = bit_q == BW'(1) ? GAP : SETUP;
            tmr_d = bit_q == BW'(1) ? GAP_L : DIV_L;
         end
         GAP: begin
            if (last) begin
               state_d = FLIP;
               tmr_d = DIV_L;
            end
         end
         FLIP: state_d = last ? IDLE : FLIP;
         default: state_d = IDLE;
      endcase
      // outputs are decoded from the next state so they register alongside it
      sclk_d = state_d == HIGH;
      flip_d = state_d == FLIP;
      rstn_d = state_d != TRST;
      busy_d = state_d != IDLE;
      done_d = state_q == FLIP && state_d == IDLE;
      sda_d = state_d == SETUP ? sh_d[DATA_LEN-1] : (state_d == HIGH || state_d == HOLD) ? sda_q : 1'b0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         sh_q <= '0;
         bit_q <= '0;
         tmr_q <= '0;
         sda_q <= 1'b0;
         sclk_q <= 1'b0;
         flip_q <= 1'b0;
         rstn_q <= 1'b0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sh_q <= sh_d;
         bit_q <= bit_d;
         tmr_q <= tmr_d;
         sda_q <= sda_d;
         sclk_q <= sclk_d;
         flip_q <= flip_d;
         rstn_q <= rstn_d;
         done_q <= done_d;
         busy_q <= busy_d;
      end
   end
   assign f.frame_ready = state_q == IDLE;
   assign f.sda = sda_q;
   assign f.sclk = sclk_q;
   assign f.flip_clk = flip_q;
   assign f.tgt_reset_n = rstn_q;
   assign f.busy = busy_q;
   assign f.done = done_q;
endmodule

// File: tb/tb_sca_frame_sender.sv
// tb_sca_frame_sender: default-parameter sender checked against a cycle-arithmetic pin model and a
// receiver/controller model; a second CLK_DIV=1/FLIP_GAP=1 sender streams random frames back-to-back.
module tb_sca_frame_sender;
   localparam int DL = 24, CD = 2, FG = 3, RL = 8;
   localparam int P = 2 * CD + 1, N = DL * P + FG + CD;
   localparam int NB = DL * 3 + 1 + 1;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0, errors = 0, cyc = 0, nb = 0, brun = 0;
   int free_at = 0, t0 = 0, done_at = -1, lo_from = 0, lo_to = -1;
   bit fact = 0, started = 0, rst_edge = 0;
   logic [DL-1:0] fd, rx, rxb;
   logic psclk, psda, pflip, pbsclk, pbsda, pbflip, pbbusy;
   bit [7:0] tgt = 8'h00;
   logic [DL-1:0] exp_q[$], expb_q[$];

   sca_frame_sender_if #(.DATA_LEN(DL)) fa ();
   sca_frame_sender_if #(.DATA_LEN(DL)) fb ();
   sca_frame_sender #(.DATA_LEN(DL), .CLK_DIV(CD), .FLIP_GAP(FG), .RST_LEN(RL)) dut_a (
      .clk(clk), .reset(reset), .f(fa.slave));
   sca_frame_sender #(.DATA_LEN(DL), .CLK_DIV(1), .FLIP_GAP(1), .RST_LEN(RL)) dut_b (
      .clk(clk), .reset(reset), .f(fb.slave));

   always #5 clk = ~clk;
   initial forever @(posedge clk) cyc++;
   initial forever begin
      @(posedge clk);
      #2 fb.frame_data = DL'($urandom);
   end
   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         if (errors <= 30) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // monitor: pin model for dut_a from accept-cycle arithmetic, receiver models for both DUTs
   initial begin
      logic [6:0] e, a;
      logic [15:0] idx;
      int o;
      bit rdy, sc, sd, fl;
      forever begin
         @(negedge clk);
         if (started) begin
            if (rst_edge) e = 7'b1000000;
            else begin
               rdy = cyc >= free_at;
               sc = 0; sd = 0; fl = 0;
               if (fact) begin
                  o = cyc - t0 - 1;
                  if (o >= 0 && o < DL * P) begin
                     sc = (o % P) >= CD && (o % P) < 2 * CD;
                     sd = fd[DL-1-o/P];
                  end
                  fl = o >= DL * P + FG && o < DL * P + FG + CD;
               end
               e = {rdy, !rdy, sc, sd, fl, !(cyc >= lo_from && cyc <= lo_to), cyc == done_at};
            end
            a = {fa.frame_ready, fa.busy, fa.sclk, fa.sda, fa.flip_clk, fa.tgt_reset_n, fa.done};
            chk("pins_a{rdy,busy,sclk,sda,flip,rstn,done}", 32'(a), 32'(e));
            if (psclk === 1'b1 && fa.sclk === 1'b0) rx = {rx[DL-2:0], fa.sda};
            if (fa.sda !== psda && !rst_edge) chk("sda_change_a{sclk,prev_sclk}", {fa.sclk, psclk}, 0);
            if (fa.flip_clk === 1'b1 && pflip === 1'b0) begin
               if (exp_q.size() == 0) chk("unexpected_flip_a", 1, 0);
               else begin
                  chk("rx_frame_a", rx, exp_q.pop_front());
                  idx = rx[DL-1 -: 16];
                  if (idx < 16'd8) tgt[idx[2:0]] = ~tgt[idx[2:0]];
               end
            end
            if (fb.sda !== pbsda && !rst_edge) chk("sda_change_b{sclk,prev_sclk}", {fb.sclk, pbsclk}, 0);
            if (pbsclk === 1'b1 && fb.sclk === 1'b0) rxb = {rxb[DL-2:0], fb.sda};
            if (fb.flip_clk === 1'b1 && pbflip === 1'b0) begin
               if (expb_q.size() == 0) chk("unexpected_flip_b", 1, 0);
               else chk("rx_frame_b", rxb, expb_q.pop_front());
            end
            if (fb.busy === 1'b1) brun++;
            else begin
               if (pbbusy === 1'b1 && !rst_edge) begin
                  chk("busy_len_b", brun, NB);
                  nb++;
               end
               brun = 0;
            end
         end
         if (reset) begin
            started = 1; rst_edge = 1; fact = 0;
            free_at = cyc + 1; done_at = -1; lo_to = -1;
            exp_q.delete(); expb_q.delete();
            rx = '0; rxb = '0;
         end else begin
            rst_edge = 0;
            if (cyc >= free_at) begin
               if (fa.tgt_rst_req) begin
                  lo_from = cyc + 1; lo_to = cyc + RL; free_at = cyc + RL + 1;
               end else if (fa.frame_valid) begin
                  t0 = cyc; fd = fa.frame_data; fact = 1;
                  free_at = cyc + N + 1; done_at = cyc + N + 1;
               end
            end
            if (fb.frame_ready && fb.frame_valid) expb_q.push_back(fb.frame_data);
         end
         psclk = fa.sclk; psda = fa.sda; pflip = fa.flip_clk;
         pbsclk = fb.sclk; pbsda = fb.sda; pbflip = fb.flip_clk; pbbusy = fb.busy;
      end
   end

   task automatic send(input logic [DL-1:0] d, input bit hold);
      bit acc = 0;
      fa.frame_data = d;
      fa.frame_valid = 1'b1;
      for (int k = 0; k < 1000 && !acc; k++) begin
         @(negedge clk);
         acc = fa.frame_ready && !fa.tgt_rst_req;
         @(posedge clk);
         #2;
      end
      chk("frame_accept_a", acc, 1);
      if (acc) exp_q.push_back(d);
      fa.frame_valid = hold;
      fa.frame_data = DL'($urandom);
   endtask

   task automatic trst();
      bit acc = 0;
      fa.tgt_rst_req = 1'b1;
      for (int k = 0; k < 1000 && !acc; k++) begin
         @(negedge clk);
         acc = fa.frame_ready;
         @(posedge clk);
         #2;
      end
      chk("rst_accept_a", acc, 1);
      fa.tgt_rst_req = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int k = 0; k < 400 && !ok; k++) begin
         @(negedge clk);
         ok = fa.frame_ready && exp_q.size() == 0;
      end
      @(posedge clk);
      #2;
      chk("idle_a", ok, 1);
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      fa.frame_data = '0; fa.frame_valid = 0; fa.tgt_rst_req = 0;
      fb.frame_valid = 0; fb.tgt_rst_req = 0;
      gap(3);
      reset = 0;
      fb.frame_valid = 1;
      gap(2);
      send(24'h0005A3, 0);
      wait_idle();
      send({16'd3, 8'h00}, 0);
      wait_idle();
      chk("tgt_bit3_first_flip", tgt[3], 1);
      send({16'd3, 8'h00}, 0);
      wait_idle();
      chk("tgt_bit3_second_flip", tgt[3], 0);
      fa.frame_valid = 1;
      fa.frame_data = 24'h0002_5C;
      trst();
      send(24'h0002_5C, 0);
      wait_idle();
      send(24'hA5C3_96, 0);
      gap(9 * P + 2);
      reset = 1;
      gap(2);
      reset = 0;
      gap(3);
      send(24'h1234_56, 0);
      wait_idle();
      send(24'hC001_0F, 1);
      gap(40);
      send(24'h7E57_81, 1);
      gap(40);
      send(24'h00FF_00, 0);
      wait_idle();
      for (int i = 0; i < 10; i++) begin
         gap($urandom_range(0, 5));
         if ($urandom_range(0, 4) == 0) trst();
         else send(DL'($urandom), 0);
         wait_idle();
      end
      chk("exp_queue_empty_a", exp_q.size(), 0);
      fb.frame_valid = 0;
      gap(200);
      chk("exp_queue_empty_b", expb_q.size(), 0);
      chk("frames_seen_b", nb >= 10, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
